multicycle_ctrl: RTL

//  Multi-cycle sequencer for the RV32 subset core: one shared ALU, one shared instruction/data memory port.

---
 rtl/multicycle_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 subset core.
// Ports: clk_i/rst_n_i, instr_i/zero_i/mem_ready_i in; datapath strobes, selects, trap_o, retire_cnt_o out.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [31:0]      instr_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             addr_sel_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_sel_o,
  output logic [1:0]       alu_a_sel_o,
  output logic [1:0]       alu_b_sel_o,
  output logic [3:0]       alu_ctrl_o,
  output logic [1:0]       shift_o,
  output logic             reg_write_o,
  output logic [1:0]       wb_sel_o,
  output logic             trap_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LD   = 7'h03;
  localparam logic [6:0] OP_ST   = 7'h23;
  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_JAL  = 7'h6F;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_IMM = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_EXEC2,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] to_cnt;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic          legal;
  logic          taken;
  logic          to_hit;
  logic          retire;
  logic          unused_bits;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};

  assign legal = opcode inside {OP_R, OP_I, OP_LD, OP_ST,
                                OP_BR, OP_JALR, OP_JAL};
  // beq/bne share one SUB; funct3[0] inverts the sense of zero
  assign taken = zero_i ^ funct3[0];
  // ready in the limit cycle still completes the request
  assign to_hit = mem_req_o && !mem_ready_i &&
                  (to_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i) state_nxt = S_DECODE;
        else if (to_hit) state_nxt = S_TRAP;
      end
      S_DECODE: state_nxt = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        unique case (opcode)
          OP_LD, OP_ST: state_nxt = S_MEM;
          OP_BR:   state_nxt = taken ? S_EXEC2 : S_FETCH;
          default: state_nxt = S_WB;
        endcase
      end
      S_EXEC2:  state_nxt = S_FETCH;
      S_MEM: begin
        if (mem_ready_i)
          state_nxt = (opcode == OP_ST) ? S_FETCH : S_WB;
        else if (to_hit)
          state_nxt = S_TRAP;
      end
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_TRAP;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    addr_sel_o  = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = 1'b0;
    alu_a_sel_o = 2'd0;
    alu_b_sel_o = 2'd0;
    alu_ctrl_o  = ALU_AND;
    shift_o     = 2'b00;
    reg_write_o = 1'b0;
    wb_sel_o    = 2'd0;
    trap_o      = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_a_sel_o = 2'd1;
        alu_b_sel_o = 2'd2;
        alu_ctrl_o  = ALU_ADD;
        ir_we_o     = mem_ready_i;
        pc_we_o     = mem_ready_i;
      end
      S_EXEC: begin
        unique case (opcode)
          OP_R: begin
            priority case (1'b1)
              funct7 != 7'd0:    alu_ctrl_o = ALU_SUB;
              funct3 == 3'b000:  alu_ctrl_o = ALU_ADD;
              funct3 == 3'b111:  alu_ctrl_o = ALU_AND;
              default:           alu_ctrl_o = ALU_OR;
            endcase
          end
          OP_I: begin
            alu_b_sel_o = 2'd1;
            alu_ctrl_o  = ALU_IMM;
            shift_o     = (funct3 == 3'b001) ? 2'b11 : 2'b10;
          end
          OP_LD, OP_ST: begin
            alu_b_sel_o = 2'd1;
            alu_ctrl_o  = ALU_ADD;
          end
          OP_BR: alu_ctrl_o = ALU_SUB;
          OP_JAL: begin
            alu_a_sel_o = 2'd2;
            alu_b_sel_o = 2'd1;
            alu_ctrl_o  = ALU_ADD;
            pc_we_o     = 1'b1;
            pc_sel_o    = 1'b1;
          end
          OP_JALR: begin
            alu_b_sel_o = 2'd1;
            alu_ctrl_o  = ALU_ADD;
            pc_we_o     = 1'b1;
            pc_sel_o    = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        alu_a_sel_o = 2'd2;
        alu_b_sel_o = 2'd1;
        alu_ctrl_o  = ALU_ADD;
        pc_we_o     = 1'b1;
        pc_sel_o    = 1'b1;
      end
      S_MEM: begin
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        mem_we_o   = (opcode == OP_ST);
      end
      S_WB: begin
        reg_write_o = 1'b1;
        if (opcode == OP_LD)
          wb_sel_o = 2'd1;
        else if (opcode == OP_JAL || opcode == OP_JALR)
          wb_sel_o = 2'd2;
      end
      S_TRAP:  trap_o = 1'b1;
      default: ;
    endcase
  end

  assign retire = (state == S_WB) || (state == S_EXEC2) ||
                  (state == S_EXEC && opcode == OP_BR && !taken) ||
                  (state == S_MEM && mem_ready_i && opcode == OP_ST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      to_cnt       <= '0;
      retire_cnt_o <= '0;
    end else begin
      if (retire)
        retire_cnt_o <= retire_cnt_o + CNT_W'(1);
      // counts stalled request cycles within one state only
      if (mem_req_o && !mem_ready_i && state_nxt == state)
        to_cnt <= to_cnt + TW'(1);
      else
        to_cnt <= '0;
    end
  end

endmodule
